// File: rtl/csr_access_unit.sv
// csr_access_unit: Zicsr read-modify-write sequencer driving the sysreg CSR port.
// Define CSR_PRIV_CHECK_EN to flag accesses above the current privilege level as illegal.
module csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic              rs1_zero,
    input  logic [4:0]        zimm,
    input  logic [1:0]        priv,
    output logic [ADDR_W-1:0] csraddr,
    output logic              csrrw,
    output logic [XLEN-1:0]   csrindata,
    input  logic [XLEN-1:0]   csroutdata,
    output logic              rd_valid,
    output logic [XLEN-1:0]   rd_data,
    output logic              illegal
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   rs1_q, rs1_d, old_q, old_d, newval_q, newval_d;
    logic [4:0]        zimm_q, zimm_d;
    logic              rs1z_q, rs1z_d, wen_q, wen_d, ill_q, ill_d;
    logic [XLEN-1:0]   src, newval;
    logic              accept, wen, ill, priv_ill;
    assign accept = state_q == IDLE && req_valid;
`ifdef CSR_PRIV_CHECK_EN
    logic [1:0] priv_q, priv_d;
    assign priv_d   = accept ? priv : priv_q;
    assign priv_ill = priv_q < addr_q[9:8];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) priv_q <= '0;
        else      priv_q <= priv_d;
    end
`else
    logic unused_priv;
    assign unused_priv = ^priv;
    assign priv_ill    = 1'b0;
`endif
    assign src    = f3_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
    assign newval = f3_q[1:0] == 2'b01 ? src
                  : f3_q[1:0] == 2'b10 ? csroutdata | src
                  : csroutdata & ~src;
    assign wen    = f3_q[1:0] == 2'b01 ? 1'b1 : f3_q[2] ? |zimm_q : !rs1z_q;
    // addr[11:10]==11 is the read-only CSR space
    assign ill    = f3_q[1:0] == 2'b00 || (wen && addr_q[11:10] == 2'b11) || priv_ill;
    always_comb begin
        state_d  = state_q == IDLE ? (req_valid ? READ : IDLE)
                 : state_q == READ ? WRITE
                 : state_q == WRITE ? DONE : IDLE;
        addr_d   = accept ? csr_addr : addr_q;
        f3_d     = accept ? funct3 : f3_q;
        rs1_d    = accept ? rs1_data : rs1_q;
        rs1z_d   = accept ? rs1_zero : rs1z_q;
        zimm_d   = accept ? zimm : zimm_q;
        old_d    = state_q == READ ? csroutdata : old_q;
        newval_d = state_q == READ ? newval : newval_q;
        wen_d    = state_q == READ ? wen : wen_q;
        ill_d    = state_q == READ ? ill : ill_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            f3_q     <= '0;
            rs1_q    <= '0;
            rs1z_q   <= 1'b0;
            zimm_q   <= '0;
            old_q    <= '0;
            newval_q <= '0;
            wen_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            rs1_q    <= rs1_d;
            rs1z_q   <= rs1z_d;
            zimm_q   <= zimm_d;
            old_q    <= old_d;
            newval_q <= newval_d;
            wen_q    <= wen_d;
            ill_q    <= ill_d;
        end
    end
    // outputs decode straight from state so reset clears the strobe without a clock
    assign req_ready = state_q == IDLE;
    assign csraddr   = addr_q;
    assign csrrw     = state_q == WRITE && wen_q && !ill_q;
    assign csrindata = state_q == WRITE ? newval_q : '0;
    assign rd_valid  = state_q == DONE;
    assign rd_data   = rd_valid && !ill_q ? old_q : '0;
    assign illegal   = rd_valid && ill_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed-vector bench for csr_access_unit (default build).
module tb_csr_access_unit;
    logic        clk, rst, req_valid, req_ready, rs1_zero, csrrw, rd_valid, illegal;
    logic [2:0]  funct3;
    logic [11:0] csr_addr, csraddr;
    logic [31:0] rs1_data, csrindata, csroutdata, rd_data;
    logic [4:0]  zimm;
    logic [1:0]  priv;
    int total = 0, bad = 0;

    csr_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data), .rs1_zero(rs1_zero),
        .zimm(zimm), .priv(priv), .csraddr(csraddr), .csrrw(csrrw), .csrindata(csrindata),
        .csroutdata(csroutdata), .rd_valid(rd_valid), .rd_data(rd_data), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // called #1 after a posedge with the unit in IDLE
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] rs1, input logic rz, input logic [4:0] zi,
                         input logic [1:0] pv, input logic [31:0] cv, input logic exp_we,
                         input logic chk_wd, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_ill);
        funct3 = f3; csr_addr = a; rs1_data = rs1; rs1_zero = rz; zimm = zi; priv = pv;
        csroutdata = cv; req_valid = 1'b1;
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk({tag, ".rd_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, ".rd_addr"}, {20'b0, csraddr}, {20'b0, a});
        chk({tag, ".rd_we"}, {31'b0, csrrw}, 32'd0);
        step();
        csroutdata = 32'hBAD0BAD0;
        chk({tag, ".wr_we"}, {31'b0, csrrw}, {31'b0, exp_we});
        chk({tag, ".wr_addr"}, {20'b0, csraddr}, {20'b0, a});
        if (chk_wd) chk({tag, ".wr_data"}, csrindata, exp_wd);
        chk({tag, ".wr_valid"}, {31'b0, rd_valid}, 32'd0);
        step();
        chk({tag, ".dn_valid"}, {31'b0, rd_valid}, 32'd1);
        chk({tag, ".dn_rd"}, rd_data, exp_rd);
        chk({tag, ".dn_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
        chk({tag, ".dn_we"}, {31'b0, csrrw}, 32'd0);
        chk({tag, ".dn_wd"}, csrindata, 32'd0);
        step();
        chk({tag, ".id_valid"}, {31'b0, rd_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; funct3 = '0; csr_addr = '0; rs1_data = '0;
        rs1_zero = 1'b0; zimm = '0; priv = 2'd3; csroutdata = '0;
        #12;
        chk("rst.ready", {31'b0, req_ready}, 32'd1);
        chk("rst.addr", {20'b0, csraddr}, 32'd0);
        chk("rst.we", {31'b0, csrrw}, 32'd0);
        chk("rst.wd", csrindata, 32'd0);
        chk("rst.valid", {31'b0, rd_valid}, 32'd0);
        chk("rst.rd", rd_data, 32'd0);
        chk("rst.ill", {31'b0, illegal}, 32'd0);
        rst = 1'b1;
        step();
        do_op("rw", 3'b001, 12'h340, 32'hDEADBEEF, 0, 0, 3, 32'h12345678, 1, 1, 32'hDEADBEEF, 32'h12345678, 0);
        do_op("rs", 3'b010, 12'h340, 32'h000000F0, 0, 0, 0, 32'h0000000F, 1, 1, 32'h000000FF, 32'h0000000F, 0);
        do_op("rc", 3'b011, 12'h340, 32'h0000000F, 0, 0, 3, 32'h000000FF, 1, 1, 32'h000000F0, 32'h000000FF, 0);
        do_op("ro_rd", 3'b010, 12'hC00, 32'h00000000, 1, 0, 3, 32'h00000064, 0, 1, 32'h00000064, 32'h00000064, 0);
        do_op("ro_rw", 3'b001, 12'hC00, 32'h00000005, 0, 0, 3, 32'h00000064, 0, 0, 32'h0, 32'h0, 1);
        do_op("f3_100", 3'b100, 12'hC00, 32'h00000005, 0, 3, 3, 32'h00000064, 0, 0, 32'h0, 32'h0, 1);
        do_op("rsi_z0", 3'b110, 12'h340, 32'h0000FFFF, 0, 0, 3, 32'h00000010, 0, 1, 32'h00000010, 32'h00000010, 0);
        do_op("rsi_z5", 3'b110, 12'h340, 32'h0000FFFF, 0, 5, 3, 32'h00000010, 1, 1, 32'h00000015, 32'h00000010, 0);
        do_op("rci", 3'b111, 12'h340, 32'h0000FFFF, 0, 5, 3, 32'h0000001F, 1, 1, 32'h0000001A, 32'h0000001F, 0);
        do_op("rwi", 3'b101, 12'h340, 32'h0000AAAA, 0, 31, 3, 32'h00000001, 1, 1, 32'h0000001F, 32'h00000001, 0);
        do_op("rs_x0", 3'b010, 12'h340, 32'h0000F000, 1, 0, 3, 32'h00000003, 0, 1, 32'h0000F003, 32'h00000003, 0);
        // reset while the write strobe is up
        funct3 = 3'b001; csr_addr = 12'h340; rs1_data = 32'h11112222; rs1_zero = 1'b0;
        csroutdata = 32'h5; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("arst.we_pre", {31'b0, csrrw}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst.we", {31'b0, csrrw}, 32'd0);
        chk("arst.ready", {31'b0, req_ready}, 32'd1);
        chk("arst.wd", csrindata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst.valid", {31'b0, rd_valid}, 32'd0);
        end
        rst = 1'b1;
        step();
        do_op("post", 3'b011, 12'h341, 32'h000000F0, 0, 0, 3, 32'h000000FF, 1, 1, 32'h0000000F, 32'h000000FF, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator-side sequencer that executes the RISC-V Zicsr instructions against the system control register block.
- Supported instructions: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
- Accepts one decoded CSR request from the core pipeline.
- Performs the read, modify and conditional write over the sysreg interface: address out, write strobe out, write data out, combinational read data in.
- Returns the old CSR value for rd, plus an illegal-instruction flag.

Parameters:
- XLEN, 32, data width of CSR values and of rs1/rd.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a CSR request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- funct3  in  3  instruction funct3 field.
- csr_addr  in  ADDR_W  CSR address from the instruction.
- rs1_data  in  XLEN  rs1 register value.
- rs1_zero  in  1  rs1 index is x0.
- zimm  in  5  immediate for the *I variants.
- priv  in  2  current privilege level; used only with the optional feature.
- csraddr  out  ADDR_W  address to sysreg.
- csrrw  out  1  sysreg write strobe; sysreg samples it on the negedge of the cycle it is high.
- csrindata  out  XLEN  write data to sysreg.
- csroutdata  in  XLEN  combinational read data from sysreg.
- rd_valid  out  1  one-cycle result pulse.
- rd_data  out  XLEN  old CSR value; 0 when illegal.
- illegal  out  1  qualified by rd_valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except req_ready=1: csraddr=0, csrrw=0, csrindata=0, rd_valid=0, rd_data=0, illegal=0.
- States: IDLE -> READ -> WRITE -> DONE -> IDLE. Fixed latency: rd_valid is high exactly 3 cycles after the accepting edge.
- IDLE:
  - req_ready=1.
  - On req_valid: register funct3, csr_addr, rs1_data, rs1_zero, zimm, priv; go to READ.
- READ:
  - csraddr = latched address; csrrw=0.
  - At the posedge: capture old=csroutdata.
  - Compute src = funct3[2] ? {27'b0, zimm} : rs1_data.
  - Compute newval (XLEN bits, no carry):
    - RW/RWI: newval = src.
    - RS/RSI: newval = old | src.
    - RC/RCI: newval = old & ~src.
  - Compute write_en:
    - RW/RWI: always 1.
    - RS/RC: !rs1_zero.
    - RSI/RCI: zimm != 0.
  - Compute illegal:
    - funct3 in {000, 100}; or
    - write_en=1 and csr_addr[11:10]==2'b11 (read-only space).
  - Go to WRITE.
- WRITE:
  - csraddr held.
  - csrindata = newval.
  - csrrw = write_en & !illegal, high for this single cycle only.
  - Go to DONE.
- DONE:
  - rd_valid=1.
  - rd_data = illegal ? 0 : old.
  - illegal driven.
  - csrrw=0.
  - Go to IDLE.
- Outside READ/WRITE, csraddr holds its last value; csrindata=0 outside WRITE.
- req_ready is low in READ/WRITE/DONE. req_valid in those states is ignored; the requester must hold it.
- Back-to-back requests: next accept occurs in the IDLE cycle after DONE, giving 4 cycles per op.
- Suppressed writes (write_en=0) still walk WRITE with csrrw=0, so latency stays constant.
- Read-only CSRs (e.g. 0xC00) with CSRRS rs1=x0 are legal reads.
- Reset asserted in WRITE: csrrw drops immediately (asynchronously). No partial-cycle guarantee beyond that. Return to IDLE; no rd_valid.
- csroutdata is sampled only in READ. Changes of counter CSRs after READ do not affect rd_data.

Optional Feature:
- CSR_PRIV_CHECK_EN
  - Defined: illegal additionally set when latched priv < csr_addr[9:8]. This is evaluated in READ and suppresses the write.
  - Undefined: priv port present but ignored; no privilege check.

Test Plan:
- CSRRW addr=0x340, rs1=0xDEADBEEF; CSR initially 0x12345678 -> csrrw high only in the WRITE cycle with csrindata=0xDEADBEEF; rd_data=0x12345678; illegal=0; rd_valid 3 cycles after accept.
- CSRRS addr=0x340, rs1=0x000000F0, CSR=0x0000000F -> csrindata=0x000000FF; then CSRRC with rs1=0x0000000F -> csrindata=0x000000F0.
- CSRRS addr=0xC00, rs1_zero=1, csroutdata=0x00000064 at READ -> csrrw never asserted; rd_data=0x64; illegal=0.
- CSRRW addr=0xC00 -> csrrw stays 0; rd_valid=1, illegal=1, rd_data=0. Repeat with funct3=100 -> same response.
- CSRRSI zimm=0 vs zimm=5 on CSR=0x10 -> zimm=0: no write, rd_data=0x10; zimm=5: csrindata=0x15.
- Assert rst=0 during WRITE of a CSRRW -> csrrw falls without waiting for a clock edge; req_ready=1; no rd_valid pulse. A following request completes normally.
